vpopc_seq: RTL and testbench



---
 rtl/vpopc_pkg.sv | 34 +++
 rtl/vpopc_rdq.sv | 103 ++++++++++
 rtl/vpopc_seq.sv | 189 ++++++++++++++++++
 tb/tb_vpopc_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpopc_pkg.sv
// Shared types and helpers for the vcpop.m sequencer: FSM states, default
// widths and the tail mask applied to the final mask chunk.
package vpopc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WAIT_RES,
        ST_RESP
    } state_t;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_VL_WIDTH   = 16;
    localparam int DEF_TAG_WIDTH  = 5;
    localparam int DEF_MAX_OUT    = 4;

    // Upper bound on supported chunk width; callers keep the low bits.
    localparam int MASK_MAX = 1024;

    // Ones in the low (vl % width) bits, or all ones when vl is a multiple.
    function automatic logic [MASK_MAX-1:0] tail_mask(input int unsigned vl,
                                                      input int unsigned width);
        logic [MASK_MAX-1:0] m;
        int unsigned rem;
        rem = vl % width;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < width) && ((rem == 0) || (i < rem));
        end
        return m;
    endfunction

endpackage

// File: rtl/vpopc_rdq.sv
// VRF read issue and credit tracker: walks the chunk addresses (v0/vs2
// interleaved when masked) and labels each in-order response.
module vpopc_rdq
    import vpopc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int VL_WIDTH   = DEF_VL_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  start_vm,
    input  logic [ADDR_WIDTH-1:0] start_vs2_addr,
    input  logic [ADDR_WIDTH-1:0] start_v0_addr,
    input  logic [VL_WIDTH-1:0]   start_nchunks,
    input  logic                  issue_en,
    input  logic                  rsp_en,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_rsp_valid,
    output logic                  last_gnt,
    output logic                  rsp_fire,
    output logic                  rsp_is_v0,
    output logic                  rsp_last
);

    localparam int CNT_W   = VL_WIDTH + 1;
    localparam int CRD_W   = $clog2(MAX_OUT) + 1;
    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);

    logic                  vm_q, vm_d;
    logic [ADDR_WIDTH-1:0] vs2_q, vs2_d, v0_q, v0_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [CNT_W-1:0]      iss_q, iss_d, rsp_q, rsp_d;
    logic [CRD_W-1:0]      crd_q, crd_d;
    logic [CNT_W-1:0]      chunk;
    logic                  iss_v0;
    logic                  gnt_fire;

    // Masked ops issue pairs: even slots fetch v0 chunk k, odd slots vs2 chunk k.
    assign iss_v0   = !vm_q && !iss_q[0];
    assign chunk    = vm_q ? iss_q : (iss_q >> 1);
    assign rd_req   = issue_en && (crd_q < CRD_W'(MAX_OUT));
    assign rd_addr  = rd_req ? ((iss_v0 ? v0_q : vs2_q) + (ADDR_WIDTH'(chunk) << BYTE_SH))
                             : '0;
    assign gnt_fire = rd_req && rd_gnt;
    assign last_gnt = gnt_fire && (iss_q == total_q - CNT_W'(1));

    // Responses are in order, so a running count identifies each one.
    assign rsp_fire  = rd_rsp_valid && rsp_en && (crd_q != '0);
    assign rsp_is_v0 = !vm_q && !rsp_q[0];
    assign rsp_last  = (rsp_q == total_q - CNT_W'(1));

    always_comb begin
        vm_d    = vm_q;
        vs2_d   = vs2_q;
        v0_d    = v0_q;
        total_d = total_q;
        iss_d   = iss_q;
        rsp_d   = rsp_q;
        crd_d   = crd_q;
        if (start) begin
            vm_d    = start_vm;
            vs2_d   = start_vs2_addr;
            v0_d    = start_v0_addr;
            total_d = start_vm ? {1'b0, start_nchunks} : {start_nchunks, 1'b0};
            iss_d   = '0;
            rsp_d   = '0;
            crd_d   = '0;
        end else begin
            if (gnt_fire) iss_d = iss_q + CNT_W'(1);
            if (rsp_fire) rsp_d = rsp_q + CNT_W'(1);
            case ({gnt_fire, rsp_fire})
                2'b10:   crd_d = crd_q + CRD_W'(1);
                2'b01:   crd_d = crd_q - CRD_W'(1);
                default: crd_d = crd_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_q <= '0;
            rsp_q <= '0;
            crd_q <= '0;
        end else begin
            iss_q <= iss_d;
            rsp_q <= rsp_d;
            crd_q <= crd_d;
        end
    end

    always_ff @(posedge clk) begin
        vm_q    <= vm_d;
        vs2_q   <= vs2_d;
        v0_q    <= v0_d;
        total_q <= total_d;
    end

endmodule

// File: rtl/vpopc_seq.sv
// vcpop.m sequencer: fetches mask chunks, forms tail/v0-masked popcount beats
// and returns the scalar count to writeback, one operation at a time.
module vpopc_seq
    import vpopc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int VL_WIDTH   = DEF_VL_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_vs2_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_v0_addr,
    input  logic                  cmd_vm,
    input  logic [VL_WIDTH-1:0]   cmd_vl,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic [DATA_WIDTH-1:0] popc_m0,
    output logic                  popc_valid,
    output logic                  popc_end,
    output logic [ADDR_WIDTH-1:0] popc_addr,
    input  logic [DATA_WIDTH-1:0] popc_res_vec,
    input  logic [ADDR_WIDTH-1:0] popc_res_addr,
    input  logic                  popc_res_valid,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [TAG_WIDTH-1:0]  res_tag,
    input  logic                  res_ready
);

    localparam int LOG2_DW = $clog2(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [TAG_WIDTH-1:0]  res_tag_q, res_tag_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [DATA_WIDTH-1:0] popc_m0_q, popc_m0_d;
    logic                  popc_valid_q, popc_valid_d;
    logic                  popc_end_q, popc_end_d;
    logic                  vm_q, vm_d;
    logic [DATA_WIDTH-1:0] last_mask_q, last_mask_d;
    logic [DATA_WIDTH-1:0] v0hold_q, v0hold_d;

    logic [MASK_MAX-1:0]   tail_full;
    logic [VL_WIDTH-1:0]   nchunks;
    logic                  accept, start, issue_en, rsp_en;
    logic                  last_gnt, rsp_fire, rsp_is_v0, rsp_last;
    logic                  unused_bits;

    assign accept    = (state_q == ST_IDLE) && cmd_valid;
    assign start     = accept && (cmd_vl != '0);
    assign nchunks   = (cmd_vl >> LOG2_DW) + VL_WIDTH'(|cmd_vl[LOG2_DW-1:0]);
    assign tail_full = tail_mask(32'(cmd_vl), DATA_WIDTH);
    assign issue_en  = (state_q == ST_ISSUE);
    assign rsp_en    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

    assign unused_bits = &{1'b0, tail_full[MASK_MAX-1:DATA_WIDTH],
                           popc_res_addr[ADDR_WIDTH-1:TAG_WIDTH]};

    vpopc_rdq #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .VL_WIDTH  (VL_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_OUT   (MAX_OUT)
    ) u_rdq (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_vm      (cmd_vm),
        .start_vs2_addr(cmd_vs2_addr),
        .start_v0_addr (cmd_v0_addr),
        .start_nchunks (nchunks),
        .issue_en      (issue_en),
        .rsp_en        (rsp_en),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_rsp_valid  (rd_rsp_valid),
        .last_gnt      (last_gnt),
        .rsp_fire      (rsp_fire),
        .rsp_is_v0     (rsp_is_v0),
        .rsp_last      (rsp_last)
    );

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        res_tag_d    = res_tag_q;
        res_data_d   = res_data_q;
        vm_d         = vm_q;
        last_mask_d  = last_mask_q;
        v0hold_d     = v0hold_q;
        popc_valid_d = 1'b0;
        popc_m0_d    = '0;
        popc_end_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tag_d       = cmd_tag;
                    vm_d        = cmd_vm;
                    last_mask_d = tail_full[DATA_WIDTH-1:0];
                    if (cmd_vl == '0) begin
                        // Empty mask: answer directly without touching the popcount unit.
                        res_data_d = '0;
                        res_tag_d  = cmd_tag;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (last_gnt) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (popc_valid_q && popc_end_q) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (popc_res_valid) begin
                    res_data_d = popc_res_vec;
                    res_tag_d  = popc_res_addr[TAG_WIDTH-1:0];
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A v0 chunk only primes the holding register; its vs2 partner makes the beat.
        if (rsp_fire) begin
            if (rsp_is_v0) begin
                v0hold_d = rd_rsp_data;
            end else begin
                popc_valid_d = 1'b1;
                popc_end_d   = rsp_last;
                popc_m0_d    = rd_rsp_data
                             & (vm_q ? {DATA_WIDTH{1'b1}} : v0hold_q)
                             & (rsp_last ? last_mask_q : {DATA_WIDTH{1'b1}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            res_tag_q    <= '0;
            res_data_q   <= '0;
            popc_valid_q <= 1'b0;
            popc_m0_q    <= '0;
            popc_end_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            res_tag_q    <= res_tag_d;
            res_data_q   <= res_data_d;
            popc_valid_q <= popc_valid_d;
            popc_m0_q    <= popc_m0_d;
            popc_end_q   <= popc_end_d;
        end
    end

    always_ff @(posedge clk) begin
        vm_q        <= vm_d;
        last_mask_q <= last_mask_d;
        v0hold_q    <= v0hold_d;
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign popc_valid = popc_valid_q;
    assign popc_m0    = popc_m0_q;
    assign popc_end   = popc_end_q;
    assign popc_addr  = ADDR_WIDTH'(tag_q);
    assign res_valid  = (state_q == ST_RESP);
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;

endmodule

// File: tb/tb_vpopc_seq.sv
// Directed bench for vpopc_seq with a VRF read-port model and a popcount unit model.
module tb_vpopc_seq;

    localparam logic [31:0] VS2_BASE = 32'h0000_0100;
    localparam logic [31:0] V0_BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_vs2_addr = '0;
    logic [31:0] cmd_v0_addr = '0;
    logic        cmd_vm = 1'b0;
    logic [15:0] cmd_vl = '0;
    logic [4:0]  cmd_tag = '0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt = 1'b0;
    logic        rd_rsp_valid = 1'b0;
    logic [63:0] rd_rsp_data = '0;
    logic [63:0] popc_m0;
    logic        popc_valid;
    logic        popc_end;
    logic [31:0] popc_addr;
    logic [63:0] popc_res_vec = '0;
    logic [31:0] popc_res_addr = '0;
    logic        popc_res_valid = 1'b0;
    logic        res_valid;
    logic [63:0] res_data;
    logic [4:0]  res_tag;
    logic        res_ready = 1'b0;

    vpopc_seq dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_vs2_addr  (cmd_vs2_addr),
        .cmd_v0_addr   (cmd_v0_addr),
        .cmd_vm        (cmd_vm),
        .cmd_vl        (cmd_vl),
        .cmd_tag       (cmd_tag),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .popc_m0       (popc_m0),
        .popc_valid    (popc_valid),
        .popc_end      (popc_end),
        .popc_addr     (popc_addr),
        .popc_res_vec  (popc_res_vec),
        .popc_res_addr (popc_res_addr),
        .popc_res_valid(popc_res_valid),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .res_ready     (res_ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic        vm;
        logic [15:0] vl;
        logic [63:0] vs2_0;
        logic [63:0] vs2_1;
        logic [63:0] v0_0;
        logic [63:0] v0_1;
        logic [63:0] exp_res;
        int          exp_beats;
        logic [63:0] exp_last;
    } vec_t;

    logic [63:0] mem [64];
    rsp_t        rq[$];
    logic [63:0] beats[$];
    logic [31:0] addrs[$];
    int          nend, cyc, lat, outst, max_outst, pend;
    int          err_idle_m0, err_req_stab;
    bit          gnt_all, inject_rsp, inject_res, prev_req_wait;
    logic [31:0] prev_addr, res_addr_l;
    logic [63:0] acc;
    int          n_pass, n_total;
    vec_t        tbl[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    // One clock cycle: observe DUT outputs at the falling edge, then drive the models.
    task automatic tick();
        rsp_t r;
        @(negedge clk);
        cyc++;
        if (popc_valid) begin
            beats.push_back(popc_m0);
            if (popc_end) nend++;
            acc += 64'($countones(popc_m0));
        end else if (popc_m0 != '0) begin
            err_idle_m0++;
        end
        popc_res_valid = 1'b0;
        popc_res_vec   = '0;
        popc_res_addr  = '0;
        if (inject_res) begin
            popc_res_valid = 1'b1;
            popc_res_vec   = 64'hDEAD;
            popc_res_addr  = 32'h1F;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                popc_res_valid = 1'b1;
                popc_res_vec   = acc;
                popc_res_addr  = res_addr_l;
                acc            = '0;
            end
        end
        if (popc_valid && popc_end) begin
            pend       = 2;
            res_addr_l = popc_addr;
        end
        if (prev_req_wait && (!rd_req || rd_addr != prev_addr)) err_req_stab++;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        if (inject_rsp) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = '1;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            r            = rq.pop_front();
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = r.data;
            outst--;
        end
        rd_gnt        = gnt_all ? 1'b1 : ((cyc % 3) != 0);
        prev_req_wait = rd_req && !rd_gnt;
        prev_addr     = rd_addr;
        if (rd_req && rd_gnt) begin
            addrs.push_back(rd_addr);
            r.data = mem[rd_addr[8:3]];
            r.due  = cyc + lat;
            rq.push_back(r);
            outst++;
            if (outst > max_outst) max_outst = outst;
        end
    endtask

    task automatic run_op(input string nm, input logic vm, input logic [15:0] vl,
                          input logic [4:0] tag, input logic [63:0] exp_res,
                          input int exp_beats, input logic [63:0] exp_last,
                          input int hold, input bit poke, output int lat_out);
        int t;
        int mism;
        logic [31:0] ea[$];
        logic [63:0] d0;
        beats.delete();
        addrs.delete();
        nend = 0;
        acc = '0;
        err_req_stab = 0;
        t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_vs2_addr = VS2_BASE;
        cmd_v0_addr  = V0_BASE;
        cmd_vm       = vm;
        cmd_vl       = vl;
        cmd_tag      = tag;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        t = 1;
        if (poke) begin
            inject_res = 1'b1;
            tick();
            inject_res = 1'b0;
            t++;
        end
        while (!res_valid && t < 3000) begin
            tick();
            t++;
        end
        lat_out = t;
        chk({nm, "_res_valid"}, 64'(res_valid), 64'd1);
        chk({nm, "_res_data"}, res_data, exp_res);
        chk({nm, "_res_tag"}, 64'(res_tag), 64'(tag));
        chk({nm, "_nbeats"}, 64'(beats.size()), 64'(exp_beats));
        chk({nm, "_nend"}, 64'(nend), (exp_beats > 0) ? 64'd1 : 64'd0);
        if (exp_beats > 0) chk({nm, "_last_beat"}, beats[beats.size()-1], exp_last);
        for (int k = 0; k < exp_beats; k++) begin
            if (!vm) ea.push_back(V0_BASE + 32'(8 * k));
            ea.push_back(VS2_BASE + 32'(8 * k));
        end
        mism = (ea.size() == addrs.size()) ? 0 : 1;
        for (int k = 0; k < ea.size() && k < addrs.size(); k++)
            if (ea[k] != addrs[k]) mism++;
        chk({nm, "_addr_order"}, 64'(mism), 64'd0);
        chk({nm, "_req_stable"}, 64'(err_req_stab), 64'd0);
        if (hold > 0) begin
            mism = 0;
            d0 = res_data;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (!res_valid || res_data != d0 || cmd_ready) mism++;
            end
            chk({nm, "_hold_stable"}, 64'(mism), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({nm, "_idle_ready"}, 64'(cmd_ready), 64'd1);
        chk({nm, "_idle_res_valid"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        int lat_cy;
        int t;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        lat = 2;
        gnt_all = 1'b0;

        tbl[0] = '{1'b1, 16'd64,  '1, '0, '0, '0, 64'd64, 1, '1};
        tbl[1] = '{1'b1, 16'd100, '1, '1, '0, '0, 64'd100, 2, 64'h0000_000F_FFFF_FFFF};
        tbl[2] = '{1'b0, 16'd64,  64'h0F0F, '0, 64'h00FF, '0, 64'd4, 1, 64'h000F};
        tbl[3] = '{1'b0, 16'd70,  64'hF0, 64'hFF, '1, '1, 64'd10, 2, 64'h3F};
        tbl[4] = '{1'b1, 16'd1,   64'h3, '0, '0, '0, 64'd1, 1, 64'h1};
        tbl[5] = '{1'b1, 16'd0,   '1, '1, '1, '1, 64'd0, 0, '0};
        tbl[6] = '{1'b0, 16'd128, '1, '1, 64'hAAAA_AAAA_AAAA_AAAA, '0, 64'd32, 2, '0};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_popc_valid", 64'(popc_valid), 64'd0);
        chk("rst_popc_end", 64'(popc_end), 64'd0);
        chk("rst_popc_m0", popc_m0, 64'd0);
        chk("rst_popc_addr", 64'(popc_addr), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_res_tag", 64'(res_tag), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            mem[32] = tbl[i].vs2_0;
            mem[33] = tbl[i].vs2_1;
            mem[0]  = tbl[i].v0_0;
            mem[1]  = tbl[i].v0_1;
            run_op($sformatf("vec%0d", i), tbl[i].vm, tbl[i].vl, 5'(3 * i + 1),
                   tbl[i].exp_res, tbl[i].exp_beats, tbl[i].exp_last, 0, 1'b0, lat_cy);
            if (tbl[i].vl == 16'd0) chk("vl0_latency", 64'(lat_cy <= 2), 64'd1);
        end

        // Long operation: saturating credits, ordered beats, writeback back-pressure.
        lat = 6;
        gnt_all = 1'b1;
        max_outst = 0;
        for (int k = 0; k < 8; k++) mem[32 + k] = (64'd1 << (k + 1)) - 64'd1;
        run_op("long", 1'b1, 16'd512, 5'd29, 64'd36, 8, 64'hFF, 5, 1'b1, lat_cy);
        chk("long_max_outstanding", 64'(max_outst), 64'd4);
        for (int k = 0; k < 8 && k < beats.size(); k++)
            chk($sformatf("long_beat%0d", k), beats[k], (64'd1 << (k + 1)) - 64'd1);

        // Reset in the middle of ISSUE with reads in flight.
        for (int k = 0; k < 8; k++) mem[32 + k] = '1;
        cmd_vs2_addr = VS2_BASE;
        cmd_v0_addr  = V0_BASE;
        cmd_vm       = 1'b1;
        cmd_vl       = 16'd512;
        cmd_tag      = 5'd7;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        t = 0;
        while (outst < 3 && t < 50) begin
            tick();
            t++;
        end
        chk("mid_outstanding", 64'(outst >= 3), 64'd1);
        rst = 1'b1;
        tick();
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_rd_req", 64'(rd_req), 64'd0);
        chk("midrst_popc_valid", 64'(popc_valid), 64'd0);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        rst = 1'b0;
        beats.delete();
        t = 0;
        while ((rq.size() > 0 || t < 3) && t < 60) begin
            tick();
            t++;
        end
        chk("late_rsp_beats", 64'(beats.size()), 64'd0);
        run_op("post_rst", 1'b1, 16'd100, 5'd11, 64'd100, 2,
               64'h0000_000F_FFFF_FFFF, 0, 1'b0, lat_cy);

        // Stale read response and popcount result while idle must be ignored.
        inject_rsp = 1'b1;
        tick();
        inject_rsp = 1'b0;
        inject_res = 1'b1;
        tick();
        inject_res = 1'b0;
        tick();
        chk("stale_res_valid", 64'(res_valid), 64'd0);
        chk("stale_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("stale_popc_valid", 64'(popc_valid), 64'd0);
        lat = 1;
        gnt_all = 1'b0;
        mem[32] = 64'h0F0F;
        mem[0]  = 64'h00FF;
        run_op("final", 1'b0, 16'd64, 5'd31, 64'd4, 1, 64'h000F, 0, 1'b0, lat_cy);

        chk("m0_zero_when_idle", 64'(err_idle_m0), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
